// File: rtl/minterm_sweeper.sv
// Truth-table sweeper: latches SoP minterm and PoS maxterm masks on start, then streams
// every input combination with both evaluated outputs and accumulates one/mismatch counts.
module minterm_sweeper #(
  parameter int N    = 3,
  parameter bit GRAY = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2**N-1:0]  minterms,
  input  logic [2**N-1:0]  maxterms,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     index,
  output logic             sop_out,
  output logic             pos_out,
  output logic             mismatch,
  output logic             busy,
  output logic             done,
  output logic [N:0]       ones_count,
  output logic [N:0]       mismatch_count,
  output logic             equivalent
);
  localparam int M = 2**N;
  localparam logic [N-1:0] K_LAST = N'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nx;
  logic [M-1:0] min_q, max_q;
  logic [N-1:0] k, comb_idx;
  logic         run, beat_acc, sop_raw, pos_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (beat_acc && k == K_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    run       = (state == RUN);
    out_valid = run;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

  // Beat outputs derive only from registers; gating by RUN keeps them at 0 outside a sweep.
  assign comb_idx   = GRAY ? (k ^ (k >> 1)) : k;
  assign sop_raw    = min_q[comb_idx];
  assign pos_raw    = ~max_q[comb_idx];
  assign index      = run ? comb_idx : '0;
  assign sop_out    = run & sop_raw;
  assign pos_out    = run & pos_raw;
  assign mismatch   = run & (sop_raw ^ pos_raw);
  assign beat_acc   = run & out_ready;
  assign equivalent = (mismatch_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q          <= '0;
      max_q          <= '0;
      k              <= '0;
      ones_count     <= '0;
      mismatch_count <= '0;
    end else if (state == IDLE && start) begin
      min_q          <= minterms;
      max_q          <= maxterms;
      k              <= '0;
      ones_count     <= '0;
      mismatch_count <= '0;
    end else if (beat_acc) begin
      ones_count     <= ones_count + {{N{1'b0}}, sop_out};
      mismatch_count <= mismatch_count + {{N{1'b0}}, mismatch};
      // k parks on the last combination instead of wrapping into a second sweep
      if (k != K_LAST) k <= k + 1'b1;
    end
  end
endmodule
